// File: rtl/popcnt_window_sum.sv
// popcnt_window_sum
//   Sliding-window accumulator for popcount results. Keeps the sum of the last
//   DEPTH accepted samples in a circular buffer and registers the sum, a
//   window-full flag and a threshold flag.
//
// Ports
//   clk_i          in   1          clock, rising edge
//   arst_n_i       in   1          asynchronous reset, active low
//   clear_i        in   1          synchronous window clear (priority over window state)
//   data_i         in   CNT_WIDTH  popcount sample
//   data_val_i     in   1          data_i valid this cycle
//   sum_o          out  SUM_WIDTH  sum of the last min(fill, DEPTH) samples
//   sum_val_o      out  1          one-cycle pulse per accepted sample
//   full_o         out  1          window holds DEPTH samples
//   over_thresh_o  out  1          sum_o >= THRESH

module popcnt_window_sum #(
    parameter int unsigned CNT_WIDTH = 4,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned THRESH    = 48
) (
    input  logic                                  clk_i,
    input  logic                                  arst_n_i,
    input  logic                                  clear_i,
    input  logic [CNT_WIDTH-1:0]                  data_i,
    input  logic                                  data_val_i,
    output logic [CNT_WIDTH+$clog2(DEPTH)-1:0]    sum_o,
    output logic                                  sum_val_o,
    output logic                                  full_o,
    output logic                                  over_thresh_o
);

    localparam int unsigned SUM_WIDTH = CNT_WIDTH + $clog2(DEPTH);
    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned FILL_W    = PTR_W + 1;
    localparam int unsigned EXT_W     = SUM_WIDTH + 1;

    typedef enum logic {
        FILLING = 1'b0,
        STEADY  = 1'b1
    } state_e;

    state_e                 state_q,     state_d;
    logic [PTR_W-1:0]       wr_ptr_q,    wr_ptr_d;
    logic [FILL_W-1:0]      fill_q,      fill_d;
    logic [SUM_WIDTH-1:0]   sum_q,       sum_d;
    logic                   sum_val_q,   sum_val_d;
    logic                   full_q,      full_d;
    logic                   over_q,      over_d;

    // Sample storage; contents are not reset because each slot is written
    // before the steady-state path ever reads it back as the oldest sample.
    logic [CNT_WIDTH-1:0]   mem_q [DEPTH];
    logic                   mem_we;
    logic [PTR_W-1:0]       mem_waddr;
    logic [CNT_WIDTH-1:0]   mem_wdata;

    logic [CNT_WIDTH-1:0]   oldest;
    logic [EXT_W-1:0]       sum_ext;
    logic [FILL_W-1:0]      fill_inc;

    assign oldest   = mem_q[wr_ptr_q];
    assign fill_inc = fill_q + FILL_W'(1);

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        fill_d    = fill_q;
        sum_d     = sum_q;
        sum_val_d = 1'b0;
        full_d    = full_q;
        over_d    = over_q;
        mem_we    = 1'b0;
        mem_waddr = wr_ptr_q;
        mem_wdata = data_i;
        sum_ext   = {1'b0, sum_q};

        if (clear_i) begin
            // A sample arriving with clear becomes the first of the new window.
            state_d  = FILLING;
            full_d   = 1'b0;
            wr_ptr_d = '0;
            fill_d   = '0;
            sum_d    = '0;
            if (data_val_i) begin
                mem_we    = 1'b1;
                mem_waddr = '0;
                wr_ptr_d  = PTR_W'(1);
                fill_d    = FILL_W'(1);
                sum_d     = SUM_WIDTH'(data_i);
                sum_val_d = 1'b1;
            end
            over_d = (32'(sum_d) >= THRESH);
        end else if (data_val_i) begin
            unique case (state_q)
                FILLING: begin
                    sum_ext = {1'b0, sum_q} + EXT_W'(data_i);
                    fill_d  = fill_inc;
                    if (fill_inc == FILL_W'(DEPTH)) begin
                        state_d = STEADY;
                        full_d  = 1'b1;
                    end
                end
                STEADY: begin
                    // Add new and drop oldest in one wider expression; the
                    // result always fits because the oldest is part of sum_q.
                    sum_ext = {1'b0, sum_q} + EXT_W'(data_i) - EXT_W'(oldest);
                end
                default: begin
                    sum_ext = {1'b0, sum_q};
                end
            endcase
            sum_d     = SUM_WIDTH'(sum_ext);
            mem_we    = 1'b1;
            wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            sum_val_d = 1'b1;
            over_d    = (32'(sum_d) >= THRESH);
        end
    end

    // Control and output registers
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q   <= FILLING;
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            sum_q     <= '0;
            sum_val_q <= 1'b0;
            full_q    <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            fill_q    <= fill_d;
            sum_q     <= sum_d;
            sum_val_q <= sum_val_d;
            full_q    <= full_d;
            over_q    <= over_d;
        end
    end

    // Circular sample buffer write port
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign sum_o         = sum_q;
    assign sum_val_o     = sum_val_q;
    assign full_o        = full_q;
    assign over_thresh_o = over_q;

endmodule

// File: tb/tb_popcnt_window_sum.sv
// Self-checking bench for popcnt_window_sum: a window model produces expected
// sums that are queued when a sample is driven and popped on sum_val_o.

module tb_popcnt_window_sum;

    localparam int unsigned CNT_WIDTH = 4;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned THRESH    = 48;
    localparam int unsigned SUM_WIDTH = CNT_WIDTH + $clog2(DEPTH);

    typedef struct {
        int sum;
        int full;
        int over;
    } exp_t;

    logic                  clk_i = 1'b0;
    logic                  arst_n_i;
    logic                  clear_i;
    logic [CNT_WIDTH-1:0]  data_i;
    logic                  data_val_i;
    logic [SUM_WIDTH-1:0]  sum_o;
    logic                  sum_val_o;
    logic                  full_o;
    logic                  over_thresh_o;

    int   n_checks = 0;
    int   n_fail   = 0;

    // Model state
    int   win[$];
    exp_t sb[$];
    int   m_sum;
    int   m_full;
    int   m_over;

    always #5 clk_i = ~clk_i;

    popcnt_window_sum #(
        .CNT_WIDTH (CNT_WIDTH),
        .DEPTH     (DEPTH),
        .THRESH    (THRESH)
    ) u_dut (
        .clk_i         (clk_i),
        .arst_n_i      (arst_n_i),
        .clear_i       (clear_i),
        .data_i        (data_i),
        .data_val_i    (data_val_i),
        .sum_o         (sum_o),
        .sum_val_o     (sum_val_o),
        .full_o        (full_o),
        .over_thresh_o (over_thresh_o)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        win.delete();
        sb.delete();
        m_sum  = 0;
        m_full = 0;
        m_over = 0;
    endtask

    // Drive one cycle of stimulus, update the model, then check after the edge.
    task automatic cycle(input bit v, input bit clr, input int d);
        exp_t e;
        bit   pushed;
        pushed     = 1'b0;
        clear_i    = clr;
        data_val_i = v;
        data_i     = CNT_WIDTH'(d);
        if (clr) begin
            win.delete();
            m_sum  = 0;
            m_full = 0;
        end
        if (v) begin
            win.push_back(d);
            if (win.size() > DEPTH) void'(win.pop_front());
            m_sum = 0;
            foreach (win[i]) m_sum += win[i];
            m_full = (win.size() == DEPTH) ? 1 : 0;
        end
        if (v || clr) m_over = (m_sum >= int'(THRESH)) ? 1 : 0;
        if (v) begin
            e.sum  = m_sum;
            e.full = m_full;
            e.over = m_over;
            sb.push_back(e);
            pushed = 1'b1;
        end
        @(posedge clk_i);
        #1;
        check_eq("sum_val", int'(sum_val_o), int'(pushed));
        if (sum_val_o && sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("sum", int'(sum_o), e.sum);
            check_eq("full", int'(full_o), e.full);
            check_eq("over", int'(over_thresh_o), e.over);
        end else begin
            check_eq("hold_sum", int'(sum_o), m_sum);
            check_eq("hold_full", int'(full_o), m_full);
            check_eq("hold_over", int'(over_thresh_o), m_over);
        end
        clear_i    = 1'b0;
        data_val_i = 1'b0;
    endtask

    initial begin
        arst_n_i   = 1'b0;
        clear_i    = 1'b0;
        data_val_i = 1'b0;
        data_i     = '0;
        model_reset();
        #12;
        check_eq("rst_sum", int'(sum_o), 0);
        check_eq("rst_val", int'(sum_val_o), 0);
        check_eq("rst_full", int'(full_o), 0);
        check_eq("rst_over", int'(over_thresh_o), 0);
        @(negedge clk_i);
        arst_n_i = 1'b1;

        // 1: fill with 12s
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 12);
            check_eq("t1_sum", int'(sum_o), 12 * (i + 1));
            check_eq("t1_over", int'(over_thresh_o), (i >= 3) ? 1 : 0);
            check_eq("t1_full", int'(full_o), (i == 7) ? 1 : 0);
        end

        // 2: steady replacement
        cycle(1'b1, 1'b0, 0);
        check_eq("t2_sum0", int'(sum_o), 84);
        cycle(1'b1, 1'b0, 3);
        check_eq("t2_sum3", int'(sum_o), 75);
        check_eq("t2_full", int'(full_o), 1);

        // 3: random samples with gaps
        for (int i = 0; i < 200; i++) begin
            cycle(($urandom_range(0, 3) != 0), 1'b0, int'($urandom_range(0, 12)));
        end

        // 4: clear with valid restarts the window
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 12);
        cycle(1'b1, 1'b1, 5);
        check_eq("t4_sum", int'(sum_o), 5);
        check_eq("t4_full", int'(full_o), 0);
        check_eq("t4_over", int'(over_thresh_o), 0);
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 5);
        check_eq("t4_full8", int'(full_o), 1);
        check_eq("t4_sum8", int'(sum_o), 40);

        // 5: clear alone, then idle
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 10);
        cycle(1'b0, 1'b1, 0);
        check_eq("t5_sum", int'(sum_o), 0);
        check_eq("t5_val", int'(sum_val_o), 0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 9);

        // 6: async reset mid-stream
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 11);
        #2;
        arst_n_i = 1'b0;
        #1;
        check_eq("t6_sum", int'(sum_o), 0);
        check_eq("t6_val", int'(sum_val_o), 0);
        check_eq("t6_full", int'(full_o), 0);
        check_eq("t6_over", int'(over_thresh_o), 0);
        model_reset();
        @(negedge clk_i);
        arst_n_i = 1'b1;
        cycle(1'b1, 1'b0, 7);
        check_eq("t6_sum7", int'(sum_o), 7);
        check_eq("t6_full7", int'(full_o), 0);

        check_eq("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
